// File: rtl/floor_call_scheduler_if.sv
// floor_call_scheduler_if
//   Bundles the call buttons, the floor-controller handshake and the status
//   outputs of floor_call_scheduler.
//   master : drives call_btn and present_floor and observes the status (the
//            floor controller side, or a testbench).
//   slave  : the scheduler itself.
//   Signals:
//     call_btn[3:0]        level-sensitive call buttons, bit i = floor i
//     present_floor[3:0]   one-hot current floor
//     requested_floor[3:0] registered one-hot target floor
//     pending[3:0]         registered outstanding-call bitmap
//     door_open            high while dwelling at a served floor
//     dir_up               sweep direction, 1 = up
//     busy                 high whenever the scheduler is not idle
//     fault                sticky flag for a non-one-hot present_floor
interface floor_call_scheduler_if;
  logic [3:0] call_btn;
  logic [3:0] present_floor;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       busy;
  logic       fault;

  modport master (
    output call_btn, present_floor,
    input  requested_floor, pending, door_open, dir_up, busy, fault
  );

  modport slave (
    input  call_btn, present_floor,
    output requested_floor, pending, door_open, dir_up, busy, fault
  );
endinterface

// File: rtl/floor_call_scheduler.sv
// floor_call_scheduler
//   Four-floor SCAN call scheduler. Latches call buttons into a pending
//   bitmap, chooses the nearest pending floor in the current sweep direction
//   (reversing when that direction is empty), drives the target to the floor
//   controller and holds the door open for DWELL_CYCLES cycles at each
//   served floor. A non-one-hot present_floor sets a sticky fault that parks
//   the scheduler until reset.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    floor_call_scheduler_if.slave (buttons, floors, status)
//   Parameter:
//     DWELL_CYCLES  door-open time in cycles, 1..255
//   Build option:
//     BTN_SYNC_EN   when defined, call_btn passes through a two-flop
//                   synchronizer, adding two cycles of button latency.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no target; requested_floor follows present_floor
//   ST_MOVE  | travelling; requested_floor = nearest SCAN target
//   ST_DWELL | door open at a served floor for DWELL_CYCLES cycles
module floor_call_scheduler #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  floor_call_scheduler_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES);

  logic [1:0] state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] req_q, req_d;
  logic       dir_q, dir_d;
  logic       fault_q, fault_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] btn;
  logic [3:0] pf;
  logic       pf_ok;
  logic [3:0] above_m, below_m, above, below;
  logic [3:0] near_up, near_dn, target;
  logic       tgt_dir;

  assign pf = bus.present_floor;

`ifdef BTN_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= bus.call_btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn = sync2_q;
`else
  assign btn = bus.call_btn;
`endif

  assign pf_ok = (pf != 4'b0000) && ((pf & (pf - 4'd1)) == 4'b0000);

  // Floors strictly above / below the current one.
  assign above_m = {pf[2] | pf[1] | pf[0], pf[1] | pf[0], pf[0], 1'b0};
  assign below_m = {1'b0, pf[3], pf[3] | pf[2], pf[3] | pf[2] | pf[1]};
  assign above   = pending_q & above_m;
  assign below   = pending_q & below_m;

  // Nearest above is the lowest set bit; nearest below is the highest.
  assign near_up = above & (~above + 4'd1);
  assign near_dn = below[3] ? 4'b1000 :
                   below[2] ? 4'b0100 :
                   below[1] ? 4'b0010 :
                   below[0] ? 4'b0001 : 4'b0000;

  always_comb begin
    target  = pf;
    tgt_dir = dir_q;
    if (dir_q) begin
      if (above != 4'b0000) begin
        target = near_up;
      end else if (below != 4'b0000) begin
        target  = near_dn;
        tgt_dir = 1'b0;
      end
    end else begin
      if (below != 4'b0000) begin
        target = near_dn;
      end else if (above != 4'b0000) begin
        target  = near_up;
        tgt_dir = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req_d     = req_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    if (fault_q || !pf_ok) begin
      // Parked: everything frozen except the forced safe outputs.
      fault_d = 1'b1;
      state_d = ST_IDLE;
      req_d   = 4'b0001;
      cnt_d   = 8'd0;
    end else begin
      // A press for the floor being dwelt at is already being served.
      pending_d = pending_q | ((state_q == ST_DWELL) ? (btn & ~pf) : btn);
      case (state_q)
        ST_IDLE: begin
          if ((pending_q & pf) != 4'b0000) state_d = ST_DWELL;
          else if (pending_q != 4'b0000)   state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if ((pf == req_q) && ((pending_q & pf) != 4'b0000)) state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (cnt_q <= 8'd1) state_d = (pending_q != 4'b0000) ? ST_MOVE : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if ((state_q == ST_DWELL) && (cnt_q != 8'd0)) cnt_d = cnt_q - 8'd1;
      // Entering DWELL: clear beats a same-cycle press for this floor.
      if ((state_d == ST_DWELL) && (state_q != ST_DWELL)) begin
        pending_d = pending_d & ~pf;
        cnt_d     = DWELL_LOAD;
      end
      if (state_d == ST_MOVE) begin
        req_d = target;
        dir_d = tgt_dir;
      end else begin
        req_d = pf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 4'b0000;
      req_q     <= 4'b0001;
      dir_q     <= 1'b1;
      fault_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.requested_floor = req_q;
  assign bus.pending         = pending_q;
  assign bus.door_open       = (state_q == ST_DWELL);
  assign bus.dir_up          = dir_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.fault           = fault_q;
endmodule

// File: tb/tb_floor_call_scheduler.sv
module tb_floor_call_scheduler;
  localparam int DW     = 4;
  localparam int TRAVEL = 4;
  localparam int MI = 0, MM = 1, MD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  floor_call_scheduler_if bus();

  floor_call_scheduler #(.DWELL_CYCLES(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state (floor indices as integers).
  int         m_state, m_req, m_cnt;
  logic [3:0] m_pend;
  bit         m_dir, m_fault;
`ifdef BTN_SYNC_EN
  logic [3:0] m_s1, m_s2;
`endif

  // Floor-controller stand-in and observation log.
  int         pos, tcnt;
  bit         use_ovr;
  logic [3:0] ovr;
  int         served[$];
  int         door_cycles;
  bit         door_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pos_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  // Nearest pending floor in sweep direction, else reverse; else stay put.
  function automatic void choose(input logic [3:0] pend, input int p, input bit dir,
                                 output int tgt, output bit nd);
    int f;
    tgt = p;
    nd  = dir;
    for (int d = 1; d < 4; d++) begin
      f = dir ? p + d : p - d;
      if (f >= 0 && f < 4 && pend[f]) begin tgt = f; return; end
    end
    for (int d = 1; d < 4; d++) begin
      f = dir ? p - d : p + d;
      if (f >= 0 && f < 4 && pend[f]) begin tgt = f; nd = !dir; return; end
    end
  endfunction

  task automatic model_reset();
    m_state = MI; m_req = 0; m_cnt = 0; m_pend = 4'b0000; m_dir = 1'b1; m_fault = 1'b0;
`ifdef BTN_SYNC_EN
    m_s1 = 4'b0000; m_s2 = 4'b0000;
`endif
  endtask

  task automatic model_edge(input logic [3:0] btn_raw, input logic [3:0] pf);
    logic [3:0] b, np;
    int p, nstate, tgt;
    bit nd;
`ifdef BTN_SYNC_EN
    b = m_s2; m_s2 = m_s1; m_s1 = btn_raw;
`else
    b = btn_raw;
`endif
    if (m_fault || ones(pf) != 1) begin
      m_fault = 1'b1; m_state = MI; m_req = 0; m_cnt = 0;
      return;
    end
    p  = pos_of(pf);
    np = m_pend | b;
    if (m_state == MD) np[p] = 1'b0;
    nstate = m_state;
    case (m_state)
      MI: if (m_pend[p]) nstate = MD; else if (m_pend != 4'b0000) nstate = MM;
      MM: if (p == m_req && m_pend[p]) nstate = MD;
      default: begin
        if (m_cnt == 1) nstate = (m_pend != 4'b0000) ? MM : MI;
        m_cnt = m_cnt - 1;
      end
    endcase
    if (nstate == MD && m_state != MD) begin np[p] = 1'b0; m_cnt = DW; end
    if (nstate == MM) begin
      choose(m_pend, p, m_dir, tgt, nd);
      m_req = tgt; m_dir = nd;
    end else begin
      m_req = p;
    end
    m_state = nstate;
    m_pend  = np;
  endtask

  task automatic mover();
    if (m_state == MM && m_req != pos) begin
      tcnt++;
      if (tcnt >= TRAVEL) begin
        tcnt = 0;
        pos  = (m_req > pos) ? pos + 1 : pos - 1;
      end
    end else begin
      tcnt = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_req;
    e_req = 4'b0001 << m_req;
    chk("requested_floor", 32'(bus.requested_floor), 32'(e_req));
    chk("pending",         32'(bus.pending),         32'(m_pend));
    chk("door_open",       32'(bus.door_open),       32'(m_state == MD));
    chk("dir_up",          32'(bus.dir_up),          32'(m_dir));
    chk("busy",            32'(bus.busy),            32'(m_state != MI));
    chk("fault",           32'(bus.fault),           32'(m_fault));
  endtask

  task automatic step(input logic [3:0] btn, input bit automove);
    if (automove) mover();
    bus.call_btn      = btn;
    bus.present_floor = use_ovr ? ovr : 4'(1 << pos);
    @(posedge clk);
    model_edge(btn, bus.present_floor);
    #1;
    compare_all();
    if (bus.door_open) door_cycles++;
    if (bus.door_open && !door_prev) served.push_back(pos_of(bus.present_floor));
    door_prev = bus.door_open;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_requested", 32'(bus.requested_floor), 32'h1);
    chk("rst_pending",   32'(bus.pending),         32'h0);
    chk("rst_door",      32'(bus.door_open),       32'h0);
    chk("rst_dir",       32'(bus.dir_up),          32'h1);
    chk("rst_busy",      32'(bus.busy),            32'h0);
    chk("rst_fault",     32'(bus.fault),           32'h0);
    model_reset();
    pos = 0; tcnt = 0; use_ovr = 1'b0; door_prev = 1'b0;
    bus.call_btn = 4'b0000;
    bus.present_floor = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step(4'b0000, 1'b1);
      n++;
    end while ((n < 4 || bus.busy || bus.pending != 4'b0000) && n < budget);
    chk({tag, "_idle_timeout"}, 32'(n < budget), 32'h1);
  endtask

  task automatic wait_door(input string tag, input bit level, input int budget);
    int n = 0;
    while (bus.door_open !== level && n < budget) begin
      step(4'b0000, 1'b1);
      n++;
    end
    chk({tag, "_door_timeout"}, 32'(n < budget), 32'h1);
  endtask

  function automatic int order_code();
    int c = 0;
    foreach (served[i]) c = c * 10 + served[i] + 1;
    return c;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rb;
    bus.call_btn = 4'b0000;
    bus.present_floor = 4'b0001;
    ovr = 4'b0000;
    do_reset();

    // Single press for floor 3 from floor 0: latency, travel, dwell.
    step(4'b1000, 1'b0);
    chk("lat_pending_n1", 32'(bus.pending), 32'h8);
    step(4'b0000, 1'b0);
    chk("lat_req_n2",  32'(bus.requested_floor), 32'h8);
    chk("lat_dir_n2",  32'(bus.dir_up), 32'h1);
    chk("lat_busy_n2", 32'(bus.busy), 32'h1);
    served.delete(); door_cycles = 0;
    run_idle("a", 200);
    chk("a_order", 32'(order_code()), 32'd4);
    chk("a_door_cycles", 32'(door_cycles), 32'(DW));

    // Back to floor 0, then 0 -> 3 with a floor-2 press on the way.
    step(4'b0001, 1'b1);
    run_idle("b0", 200);
    step(4'b1000, 1'b1);
    n = 0;
    while (pos != 1 && n < 100) begin step(4'b0000, 1'b1); n++; end
    chk("b_reach_f1", 32'(n < 100), 32'h1);
    served.delete();
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    chk("b_retarget", 32'(bus.requested_floor), 32'h4);
    run_idle("b", 200);
    chk("b_order", 32'(order_code()), 32'd34);

    // From floor 0: serve 2 heading up with {0,3} pending; expect 3 then 0.
    step(4'b0001, 1'b1);
    run_idle("c0", 200);
    served.delete();
    step(4'b0100, 1'b1);
    wait_door("c_f2", 1'b1, 100);
    step(4'b1001, 1'b1);
    wait_door("c_f2_end", 1'b0, 100);
    wait_door("c_f3", 1'b1, 100);
    wait_door("c_f3_end", 1'b0, 100);
    chk("c_dir_after_f3", 32'(bus.dir_up), 32'h0);
    chk("c_req_after_f3", 32'(bus.requested_floor), 32'h1);
    run_idle("c", 200);
    chk("c_order", 32'(order_code()), 32'd341);

    // Re-press of the dwell floor is discarded; then a bad floor code.
    served.delete(); door_cycles = 0;
    step(4'b0001, 1'b1);
    n = 0;
    do begin
      step(bus.door_open ? 4'b0001 : 4'b0000, 1'b1);
      n++;
    end while ((n < 4 || bus.busy || bus.pending != 4'b0000) && n < 100);
    chk("d_idle_timeout", 32'(n < 100), 32'h1);
    chk("d_order", 32'(order_code()), 32'd1);
    chk("d_door_cycles", 32'(door_cycles), 32'(DW));
    chk("d_pending", 32'(bus.pending), 32'h0);
    use_ovr = 1'b1; ovr = 4'b0110;
    step(4'b0000, 1'b0);
    chk("d_fault_set", 32'(bus.fault), 32'h1);
    chk("d_fault_req", 32'(bus.requested_floor), 32'h1);
    use_ovr = 1'b0; pos = 2;
    for (int i = 0; i < 6; i++) step(4'($urandom_range(0, 15)), 1'b0);
    chk("d_fault_hold", 32'(bus.fault), 32'h1);
    do_reset();

    // Asynchronous reset mid-dwell with pending = 1010.
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b0000, 1'b0);
    chk("e_pre_pending", 32'(bus.pending), 32'hA);
    chk("e_pre_door", 32'(bus.door_open), 32'h1);
    do_reset();

    // Randomized calls with the floor controller following the target.
    for (int i = 0; i < 500; i++) begin
      rb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step(rb, 1'b1);
    end
    run_idle("rand", 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/floor_call_scheduler.md
FLOOR_CALL_SCHEDULER -- requirements
Module: floor_call_scheduler

Interface
REQ-001 SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 SHALL have parameter DWELL_CYCLES, default 4, range 1..255: number of cycles door_open is held at a served floor.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 call_btn  input  4  level-sensitive call buttons, bit i = floor i.
REQ-006 present_floor  input  4  one-hot current floor from the floor controller (0001 = floor 0 ... 1000 = floor 3).
REQ-007 requested_floor  output  4  registered one-hot target floor driven to the floor controller.
REQ-008 pending  output  4  registered outstanding-call bitmap.
REQ-009 door_open  output  1  high while dwelling at a served floor.
REQ-010 dir_up  output  1  current sweep direction: 1 = up, 0 = down.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 fault  output  1  sticky flag for a non-one-hot present_floor.

Function
REQ-013 SHALL implement three states: IDLE, MOVE and DWELL.
REQ-014 Each cycle, any call_btn[i] high SHALL set pending[i] on the next edge, except in REQ-015.
REQ-015 In DWELL, a press for the current floor SHALL be discarded; pending for that floor stays 0.
REQ-016 Target selection (SCAN): nearest pending floor above present_floor if dir_up=1, else nearest below.
REQ-016a If the current direction has no pending floor, direction SHALL flip and the nearest floor in the new direction is chosen.
REQ-017 Target SHALL be recomputed every cycle in MOVE; a new call between present_floor and target in the sweep direction retargets to it.
REQ-018 IDLE: requested_floor = present_floor.
REQ-018a IDLE -> DWELL when pending includes present_floor; IDLE -> MOVE when another floor is pending.
REQ-019 MOVE: requested_floor = target; MOVE -> DWELL on the edge where present_floor equals target and target is pending.
REQ-020 Entering DWELL SHALL clear that floor's pending bit and load the dwell counter with DWELL_CYCLES.
REQ-020a door_open SHALL be high for exactly DWELL_CYCLES cycles; requested_floor = present_floor during DWELL.
REQ-021 On DWELL expiry the next state is MOVE if pending is nonzero, else IDLE.
REQ-022 Latency: press in cycle N -> pending at N+1 -> requested_floor updated at N+2.
REQ-023 If present_floor is not one-hot for any cycle, fault SHALL set next edge and hold until reset.
REQ-023a While fault=1: requested_floor = 0001, state IDLE, pending frozen, door_open 0.
REQ-024 Simultaneous set and clear of the same pending bit: clear wins only for the DWELL floor; set wins otherwise.
REQ-025 Dwell counter SHALL be 8 bits, decrementing to 0 with no wrap.

Reset
REQ-026 Assertion of rst_n SHALL immediately, independent of clk, force:
  - IDLE, pending=0000, requested_floor=0001
  - door_open=0, dir_up=1, busy=0, fault=0, dwell counter=0
REQ-027 Reset mid-MOVE or mid-DWELL SHALL abandon all pending calls; operation resumes on the first clk edge after rst_n deassertion.

Configuration
REQ-028 With BTN_SYNC_EN defined, call_btn SHALL pass through a two-flop synchronizer (reset to 0) before REQ-014; press-to-pending latency becomes 3 cycles and requested_floor latency 4.
REQ-029 Without BTN_SYNC_EN, call_btn SHALL feed REQ-014 directly with the latency of REQ-022.

Verification
REQ-030 Reset, present_floor=0001, pulse call_btn=1000 for 1 cycle:
  - pending=1000 at N+1; requested_floor=1000, dir_up=1, busy=1 at N+2.
REQ-031 Model moves 0001->0010->0100->1000:
  - DWELL on arrival, pending=0000, door_open high exactly 4 cycles, then IDLE.
REQ-032 At floor 0 heading to floor 3, press floor 2 while present_floor=0010:
  - requested_floor retargets to 0100; floor 2 served first, then 1000.
REQ-033 At floor 2 with dir_up=1, pending={0001,1000}:
  - floor 3 served first, then dir_up=0 and requested_floor=0001.
REQ-034 Press floor-0 button during DWELL at floor 0 -> pending stays 0000, no second dwell.
  - Then drive present_floor=0110 -> fault=1, requested_floor=0001, held until rst_n low.
REQ-035 Assert rst_n low mid-DWELL with pending=1010:
  - all outputs take REQ-026 values the same cycle, with no clk edge needed.
